cart_mem_arbiter: RTL

CART_MEM_ARBITER -- requirements
Module: cart_mem_arbiter

---
 rtl/cart_mem_arbiter.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/cart_mem_arbiter.sv
// Shares the cartridge memory bus between the Game Boy and a host port; the
// host only gets the bus after a guard window of Game Boy inactivity.
module cart_mem_arbiter #(
    parameter int unsigned STROBE_CYC = 3,
    parameter int unsigned GUARD_CYC  = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        gb_rst_i,
    input  logic        rom_cs_i,
    input  logic        ram_cs_i,
    input  logic        host_req_i,
    input  logic        host_we_i,
    input  logic [22:0] host_a_i,
    input  logic [7:0]  host_wd_i,
    input  logic [7:0]  mem_di_i,
    output logic        bus_gb_o,
    output logic [22:0] mem_a_o,
    output logic [7:0]  mem_do_o,
    output logic        mem_doe_o,
    output logic        mem_cs_n_o,
    output logic        mem_oe_n_o,
    output logic        mem_we_n_o,
    output logic        host_ack_o,
    output logic [7:0]  host_rd_o,
    output logic        host_abort_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GUARD,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_DONE
    } state_t;

    localparam logic [3:0] GUARD_L     = 4'(GUARD_CYC);
    localparam logic [3:0] STRB_LAST_L = 4'(STROBE_CYC - 1);
    // Synchronizer reset levels, ordered {gb_rst, rom_cs, ram_cs}: GB in reset, chips deselected.
    localparam logic [2:0] SYNC_INIT   = 3'b011;

    logic [2:0]  sync1_q, sync2_q;
    logic        gb_act;

    state_t      state_q, state_d;
    logic [3:0]  idle_cnt_q, idle_cnt_d;
    logic [3:0]  strb_cnt_q, strb_cnt_d;
    logic        abort_q, abort_d;
    logic        we_q;
    logic [22:0] mem_a_q;
    logic [7:0]  mem_do_q;
    logic [7:0]  host_rd_q;
    logic        load_req;
    logic        capture_rd;
    logic        in_access;
    logic        in_strobe;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= SYNC_INIT;
            sync2_q <= SYNC_INIT;
        end else begin
            sync1_q <= {gb_rst_i, rom_cs_i, ram_cs_i};
            sync2_q <= sync1_q;
        end
    end

    assign gb_act = sync2_q[2] & (~sync2_q[1] | ~sync2_q[0]);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            idle_cnt_q <= 4'd0;
            strb_cnt_q <= 4'd0;
            abort_q    <= 1'b0;
            we_q       <= 1'b0;
            mem_a_q    <= 23'd0;
            mem_do_q   <= 8'd0;
            host_rd_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            strb_cnt_q <= strb_cnt_d;
            abort_q    <= abort_d;
            if (load_req) begin
                mem_a_q <= host_a_i;
                we_q    <= host_we_i;
                if (host_we_i) begin
                    mem_do_q <= host_wd_i;
                end
            end
            if (capture_rd) begin
                host_rd_q <= mem_di_i;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        strb_cnt_d = strb_cnt_q;
        abort_d    = 1'b0;
        load_req   = 1'b0;
        capture_rd = 1'b0;

        // The guard window restarts with each new request so a long-idle
        // bus cannot shortcut it; any GB activity also restarts it.
        if (gb_act || (state_q == S_IDLE && host_req_i)) begin
            idle_cnt_d = 4'd0;
        end else if (idle_cnt_q != GUARD_L) begin
            idle_cnt_d = idle_cnt_q + 4'd1;
        end else begin
            idle_cnt_d = idle_cnt_q;
        end

        case (state_q)
            S_IDLE: begin
                if (host_req_i) begin
                    state_d = S_GUARD;
                end
            end
            S_GUARD: begin
                if (idle_cnt_q == GUARD_L && !gb_act) begin
                    state_d  = S_SETUP;
                    load_req = 1'b1;
                end
            end
            S_SETUP: begin
                strb_cnt_d = 4'd0;
                if (gb_act) begin
                    state_d = S_GUARD;
                    abort_d = 1'b1;
                end else begin
                    state_d = S_STROBE;
                end
            end
            S_STROBE: begin
                if (!we_q && strb_cnt_q == STRB_LAST_L) begin
                    capture_rd = 1'b1;
                end
                if (gb_act) begin
                    state_d = S_GUARD;
                    abort_d = 1'b1;
                end else if (strb_cnt_q == STRB_LAST_L) begin
                    state_d = S_HOLD;
                end else begin
                    strb_cnt_d = strb_cnt_q + 4'd1;
                end
            end
            S_HOLD: begin
                if (gb_act) begin
                    state_d = S_GUARD;
                    abort_d = 1'b1;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Strobes decode straight from the registered state, so a preemption or
    // reset releases the bus on the very next cycle.
    assign in_access = (state_q == S_SETUP) || (state_q == S_STROBE) || (state_q == S_HOLD);
    assign in_strobe = (state_q == S_STROBE);

    assign bus_gb_o     = ~in_access;
    assign mem_cs_n_o   = ~in_access;
    assign mem_oe_n_o   = ~(in_strobe & ~we_q);
    assign mem_we_n_o   = ~(in_strobe & we_q);
    assign mem_doe_o    = in_access & we_q;
    assign mem_a_o      = mem_a_q;
    assign mem_do_o     = mem_do_q;
    assign host_ack_o   = (state_q == S_DONE);
    assign host_rd_o    = host_rd_q;
    assign host_abort_o = abort_q;

endmodule
